// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment helper for the multiplexed 7-segment display path.
// Patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF_AL = 8'hFF;

    // Entry k is the pattern for hex code k (entry 0 sits in the low byte).
    localparam logic [15:0][7:0] HEX_SEG_AL = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] code, input logic dp);
        logic [7:0] pat;
        pat    = HEX_SEG_AL[code];
        pat[7] = ~dp;
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational digit decoder: hex code plus decimal point to an active-low segment byte,
// with separate blanking of the a-g segments and of the whole digit.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank_ag,
    input  logic       blank_all,
    output logic [7:0] seg_al
);

    // Whole-digit blanking wins over a-g blanking, so a blinking digit hides its dp too.
    always_comb begin
        seg_al = hex_to_seg(code, dp);
        if (blank_ag) begin
            seg_al[6:0] = 7'h7F;
        end
        if (blank_all) begin
            seg_al = SEG_OFF_AL;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver: walks the digits most-significant first and drives
// the shared segment bus and one-hot digit select from one register stage.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 1,
    parameter int BLINK_HALF     = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                      clk_1khz,
    input  logic                      rstn,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blink,
    input  logic                      lz_en,
    input  logic                      en,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     sel,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [IW-1:0]         IDX_TOP = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{1'(SEL_ACTIVE_LOW != 0)}};

    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_ph;
    logic                  run;
    logic                  vld_p0;
    logic [IW-1:0]         idx_p0;
    logic [3:0]            code_p0;
    logic                  dp_p0;
    logic                  blank_ag_p0;
    logic                  blank_all_p0;
    logic [7:0]            pat_al_p0;
    logic [7:0]            seg_p0;
    logic [NUM_DIGITS-1:0] sel_p0;
    logic [NUM_DIGITS-1:0] onehot_p0;
    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  all_zero;

    assign vld_p0 = (div_cnt == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk_1khz or negedge rstn) begin
        if (!rstn) begin
            div_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            div_cnt <= vld_p0 ? '0 : div_cnt + DW'(1);
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // The first step after reset shows the top digit itself rather than stepping past it.
    always_comb begin
        if (!run) begin
            idx_p0 = scan_idx;
        end else if (scan_idx == '0) begin
            idx_p0 = IDX_TOP;
        end else begin
            idx_p0 = scan_idx - IW'(1);
        end
    end

    // A digit is a leading zero when it and everything to its left is zero.
    always_comb begin
        lz_vec   = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero  = all_zero & (digits[4*k +: 4] == 4'h0);
            lz_vec[k] = lz_en & all_zero & (k != 0);
        end
    end

    always_comb begin
        code_p0      = digits[{idx_p0, 2'b00} +: 4];
        dp_p0        = dp[idx_p0];
        blank_ag_p0  = lz_vec[idx_p0];
        blank_all_p0 = blink_ph & blink[idx_p0];
    end

    seg7_hex_decode u_dec (
        .code      (code_p0),
        .dp        (dp_p0),
        .blank_ag  (blank_ag_p0),
        .blank_all (blank_all_p0),
        .seg_al    (pat_al_p0)
    );

    always_comb begin
        onehot_p0 = NUM_DIGITS'(1) << idx_p0;
        seg_p0    = (SEG_ACTIVE_LOW != 0) ? pat_al_p0 : ~pat_al_p0;
        sel_p0    = (SEL_ACTIVE_LOW != 0) ? ~onehot_p0 : onehot_p0;
    end

    // ---- stage p0 -> outputs: segment, select and index load together on a step ----
    always_ff @(posedge clk_1khz or negedge rstn) begin
        if (!rstn) begin
            seg      <= SEG_OFF;
            sel      <= SEL_OFF;
            scan_idx <= IDX_TOP;
            run      <= 1'b0;
        end else if (vld_p0) begin
            scan_idx <= idx_p0;
            run      <= 1'b1;
            if (en) begin
                seg <= seg_p0;
                sel <= sel_p0;
            end else begin
                seg <= SEG_OFF;
                sel <= SEL_OFF;
            end
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scan driver for the digital-clock display path.
- Takes NUM_DIGITS packed 4-bit digit codes and time-multiplexes them onto one shared segment bus, with one-hot digit selects.
- Adds full hex decode, per-digit decimal point, per-digit blink for time-set mode, leading-zero suppression and a display enable.
- Segment and select outputs are registered together, so the segment pattern always matches the enabled digit.

Parameters:
- NUM_DIGITS, 6: number of scanned digits; legal range 1..16.
- SCAN_DIV, 1: clk_1khz cycles each digit is held (dwell); minimum 1.
- BLINK_HALF, 500: clk_1khz cycles per blink half-period (500 gives 1 Hz blink at 1 kHz).
- SEG_ACTIVE_LOW, 1: 1 drives segments low to light them; 0 drives them high.
- SEL_ACTIVE_LOW, 1: 1 drives the enabled digit select low; 0 drives it high.

Ports:
- clk_1khz  in  1  scan clock.
- rstn  in  1  asynchronous active-low reset.
- digits  in  4*NUM_DIGITS  digit k occupies bits [4k+3:4k]; digit 0 is the rightmost digit.
- dp  in  NUM_DIGITS  decimal point request, one bit per digit.
- blink  in  NUM_DIGITS  blink enable, one bit per digit.
- lz_en  in  1  leading-zero suppression enable.
- en  in  1  display enable.
- seg  out  8  segment bus {dp,g,f,e,d,c,b,a}.
- sel  out  NUM_DIGITS  one-hot digit select.
- scan_idx  out  max(1,$clog2(NUM_DIGITS))  index of the digit currently driven.

Behaviour:
- Reset (async assert, sync release):
  - seg = all off (8'hFF when SEG_ACTIVE_LOW=1).
  - sel = all inactive.
  - scan_idx = NUM_DIGITS-1.
  - Prescaler and blink counter = 0; blink phase = 0.
- Prescaler:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - A step fires in the cycle where div_cnt == SCAN_DIV-1.
  - With SCAN_DIV=1 a step fires every cycle.
- Scan order on each step:
  - scan_idx decrements, so digits are scanned left to right (most significant first).
  - Wrap: index 0 goes to NUM_DIGITS-1.
  - NUM_DIGITS=1: index stays at 0.
- Output registers:
  - Loaded only on a step, for the new index n, using input values sampled in that cycle.
  - Loaded values become visible on the next edge, i.e. 1-cycle latency.
  - Input changes mid-dwell have no effect until the next step.
- Digit content for index n:
  - 4-bit code decoded as full hex 0-F. Active-low patterns: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - dp[n]=1 lights bit7.
  - SEG_ACTIVE_LOW=0 inverts the whole byte.
- Leading-zero suppression:
  - Digit n is LZ-blanked when lz_en=1, n != 0, and every digit j >= n has code 0.
  - LZ-blanked digit: segments a-g off; dp still honoured.
  - Digit 0 is never suppressed.
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1; on wrap the phase toggles.
  - Runs freely, independent of en and of steps.
  - When phase=1 and blink[n]=1, all 8 segments of digit n are off, dp included.
  - Blink takes priority over LZ and dp.
- Select:
  - sel bit n is active, all other bits inactive.
  - This holds even when digit n is blanked, so scan timing stays constant.
- Enable:
  - With en=0, the next step loads seg = all off and sel = all inactive.
  - Counters and scan_idx keep running.
  - Re-enable takes effect at the next step.
- Simultaneous events: a step and a blink-phase toggle in the same cycle use the pre-toggle phase.
- Reset mid-dwell: outputs go immediately to their reset values; scanning restarts at NUM_DIGITS-1 after release, with the first step on the first post-release cycle where div_cnt == SCAN_DIV-1.
- Invariant: no outputs toggle except on a step edge or on reset.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF_AL = 8'hFF.
  - A 16-entry active-low hex pattern constant table.
  - Function hex_to_seg(code, dp).
- Sub-module seg7_hex_decode: combinational {code, dp, blank_ag, blank_all} -> 8-bit active-low pattern. Instantiated once in seg7_scan_ctrl; the polarity inversion is applied in seg7_scan_ctrl.

Test Plan:
- Basic scan, NUM_DIGITS=6, SCAN_DIV=1, digits=24'h123456, dp=0, lz_en=0, en=1, blink=0, release reset -> from the first edge after release, repeating sequence (sel, seg): (011111,F9) (101111,A4) (110111,B0) (111011,99) (111101,92) (111110,82); scan_idx goes 5..0.
- Hex/dp, digits=24'hABCDEF, dp=6'b000001 -> digit0 seg 0E (F with dp lit); digits 5..1 show 88,83,C6,A1,86.
- LZ, digits=24'h000705, lz_en=1 -> digits 5,4,3 FF; digit2 F8; digit1 C0 (internal zero kept); digit0 92. digits=0 -> only digit0 shows C0.
- Blink, BLINK_HALF=4, blink=6'b110000 -> digits 5,4 read FF during alternating 4-cycle phase-1 windows and normal patterns otherwise; sel pattern unchanged throughout.
- Dwell/enable, SCAN_DIV=3 -> each sel value held exactly 3 cycles. Deassert en -> at the next step sel=111111, seg=FF. Reassert -> scanning resumes at the current scan_idx.
- Reset mid-dwell, assert rstn=0 at cycle 2 of a 3-cycle dwell -> seg=FF and sel=111111 immediately (async). After release, first step drives scan_idx=5.
